// File: rtl/pipeline_stage_memory_multicycle_if.sv
// Data-memory request/acknowledge bus between the MEM stage and a variable-latency data memory.
// The stage drives req/we/addr/wdata/be and holds them until the memory returns ack (+ rdata).
interface pipeline_stage_memory_multicycle_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         be;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/pipeline_stage_memory_multicycle.sv
// MEM pipeline stage between EX and WB. Issues one data-memory access at a time over a req/ack
// bus, stalls EX while it is outstanding, aligns store lanes and extends load data, flags
// misaligned accesses and memory timeouts, and publishes a forwarding record for hazard logic.
module pipeline_stage_memory_multicycle #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned REG_ID_WIDTH = 5,
  parameter int unsigned MAX_WAIT     = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0]   in_alu_result,
  input  logic [DATA_WIDTH-1:0]   in_store_data,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  input  logic                    in_reg_write,
  input  logic [REG_ID_WIDTH-1:0] in_reg_id,
  input  logic                    in_data_ready,
  pipeline_stage_memory_multicycle_if.master dm,
  output logic                    out_valid,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [REG_ID_WIDTH-1:0] out_reg_id,
  output logic                    out_reg_write,
  output logic                    out_data_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [REG_ID_WIDTH-1:0] fwd_reg_id,
  output logic                    fwd_data_ready,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    err_misaligned,
  output logic                    err_timeout
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned CW = 16;
  localparam logic [NB-1:0]         BeOne    = {{(NB - 1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DataOne  = {{(DATA_WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         WaitLast = CW'(MAX_WAIT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [NB-1:0]           be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [1:0]              size;
    logic                    is_unsigned;
    logic [LB-1:0]           lane;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [REG_ID_WIDTH-1:0] reg_id;
    logic                    reg_write;
  } req_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   pc;
    logic [REG_ID_WIDTH-1:0] reg_id;
    logic                    reg_write;
    logic                    data_ready;
    logic [DATA_WIDTH-1:0]   data;
  } result_t;

  // A result that writes no register: ready with zero data on register ZERO.
  localparam result_t Bubble = '{pc: '0, reg_id: '0, reg_write: 1'b0, data_ready: 1'b1, data: '0};

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  result_t       out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          mis_q, mis_d;
  logic          to_q, to_d;

  int unsigned           acc_bytes;
  logic [LB-1:0]         acc_lane;
  logic                  acc_mem;
  logic                  acc_ok;
  logic [NB-1:0]         acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_addr;

  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_mask;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic                  ld_sign;

  // Decode the incoming access: legality, alignment, lane-aligned enables and write data.
  always_comb begin
    acc_bytes = 32'd1 << in_size;
    acc_lane  = in_alu_result[LB-1:0];
    acc_mem   = in_mem_read | in_mem_write;
    acc_ok    = (acc_bytes <= NB) && ((32'(acc_lane) & (acc_bytes - 32'd1)) == 32'd0);
    acc_be    = ((BeOne << acc_bytes) - BeOne) << acc_lane;
    acc_wdata = in_store_data << {acc_lane, 3'b000};
    acc_addr  = ADDR_WIDTH'(in_alu_result);
    acc_addr[LB-1:0] = '0;
  end

  // Shift the returned word down to its lane, keep 2^size bytes, then sign- or zero-extend.
  always_comb begin
    ld_shift = dm.rdata >> {req_q.lane, 3'b000};
    // Shifting by the full width yields zero, so a full-width access gets an all-ones mask.
    ld_mask  = (DataOne << (32'd8 << req_q.size)) - DataOne;
    unique case (req_q.size)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_WIDTH-1];
    endcase
    ld_ext = (ld_shift & ld_mask) |
             ({DATA_WIDTH{ld_sign & ~req_q.is_unsigned}} & ~ld_mask);
  end

  // Next state: accept in IDLE, wait for ack (or give up after MAX_WAIT cycles) in WAIT.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_d       = Bubble;
    mis_d       = 1'b0;
    to_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!acc_mem) begin
            out_valid_d = 1'b1;
            out_d.pc    = in_pc;
            if (in_reg_write) begin
              out_d.reg_id     = in_reg_id;
              out_d.reg_write  = 1'b1;
              out_d.data_ready = in_data_ready;
              out_d.data       = in_alu_result;
            end
          end else if (acc_ok) begin
            state_d           = StWait;
            cnt_d             = '0;
            req_d.addr        = acc_addr;
            req_d.we          = in_mem_write;
            req_d.be          = acc_be;
            req_d.wdata       = acc_wdata;
            req_d.size        = in_size;
            req_d.is_unsigned = in_unsigned;
            req_d.lane        = acc_lane;
            req_d.pc          = in_pc;
            req_d.reg_id      = in_reg_id;
            // Stores never write a register.
            req_d.reg_write   = in_reg_write & in_mem_read;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (dm.ack) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          out_d.pc    = req_q.pc;
          if (req_q.reg_write) begin
            out_d.reg_id     = req_q.reg_id;
            out_d.reg_write  = 1'b1;
            out_d.data_ready = 1'b1;
            out_d.data       = ld_ext;
          end
        end else if (cnt_q == WaitLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State, request latch, result and error-pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      req_q       <= '0;
      cnt_q       <= '0;
      out_q       <= Bubble;
      out_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mis_q       <= mis_d;
      to_q        <= to_d;
    end
  end

  assign in_ready       = (state_q == StIdle);
  assign dm.req         = (state_q == StWait);
  assign dm.we          = (state_q == StWait) && req_q.we;
  assign dm.addr        = req_q.addr;
  assign dm.wdata       = req_q.wdata;
  assign dm.be          = req_q.be;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign out_reg_id     = out_q.reg_id;
  assign out_reg_write  = out_q.reg_write;
  assign out_data_ready = out_q.data_ready;
  assign out_data       = out_q.data;
  assign err_misaligned = mis_q;
  assign err_timeout    = to_q;

  // Forwarding record: a bubble looks like a ready write of zero to register ZERO.
  always_comb begin
    fwd_reg_id     = '0;
    fwd_data_ready = 1'b1;
    fwd_data       = '0;
    if (out_valid_q) begin
      fwd_reg_id     = out_q.reg_id;
      fwd_data_ready = out_q.data_ready;
      fwd_data       = out_q.data;
    end
  end
endmodule

// File: tb/tb_pipeline_stage_memory_multicycle.sv
// Bench for pipeline_stage_memory_multicycle: directed cases plus randomized instructions,
// each checked against a transaction-level model of the stage.
module tb_pipeline_stage_memory_multicycle;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_store_data;
  logic          in_mem_read;
  logic          in_mem_write;
  logic [1:0]    in_size;
  logic          in_unsigned;
  logic          in_reg_write;
  logic [RW-1:0] in_reg_id;
  logic          in_data_ready;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [RW-1:0] out_reg_id;
  logic          out_reg_write;
  logic          out_data_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] fwd_reg_id;
  logic          fwd_data_ready;
  logic [DW-1:0] fwd_data;
  logic          err_misaligned;
  logic          err_timeout;

  pipeline_stage_memory_multicycle_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dm_bus ();

  pipeline_stage_memory_multicycle #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ID_WIDTH(RW), .MAX_WAIT(MW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_reg_write(in_reg_write), .in_reg_id(in_reg_id), .in_data_ready(in_data_ready),
    .dm(dm_bus), .out_valid(out_valid), .out_pc(out_pc), .out_reg_id(out_reg_id),
    .out_reg_write(out_reg_write), .out_data_ready(out_data_ready), .out_data(out_data),
    .fwd_reg_id(fwd_reg_id), .fwd_data_ready(fwd_data_ready), .fwd_data(fwd_data),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bubble();
    check_val("idle_out_valid", 64'(out_valid), 64'd0);
    check_val("idle_fwd_id", 64'(fwd_reg_id), 64'd0);
    check_val("idle_fwd_ready", 64'(fwd_data_ready), 64'd1);
    check_val("idle_fwd_data", 64'(fwd_data), 64'd0);
    check_val("idle_err_mis", 64'(err_misaligned), 64'd0);
    check_val("idle_err_to", 64'(err_timeout), 64'd0);
  endtask

  // Present one instruction, act as the memory (ack in WAIT cycle k), and check the outcome.
  task automatic do_op(input bit rd, input bit wr, input bit [1:0] size, input bit uns,
                       input bit rw, input bit [4:0] id, input bit dr, input bit [31:0] alu,
                       input bit [31:0] sdata, input bit [31:0] pc, input int k,
                       input bit [31:0] rdata);
    int unsigned bytes, lane;
    bit          ok;
    bit [63:0]   mask, val;
    bit [31:0]   e_data;
    bit [4:0]    e_id;
    bit          e_ready, e_rw;
    bit [3:0]    e_be;
    bit [31:0]   e_wdata;
    bytes   = 32'd1 << size;
    lane    = alu % 4;
    ok      = (bytes <= 4) && (lane % bytes == 0);
    e_be    = 4'(((32'd1 << bytes) - 1) << lane);
    e_wdata = sdata << (8 * lane);
    e_rw    = 1'b0;
    e_id    = 5'd0;
    e_ready = 1'b1;
    e_data  = 32'd0;
    if (!rd && !wr && rw) begin
      e_rw = 1'b1; e_id = id; e_ready = dr; e_data = alu;
    end else if (rd && rw) begin
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      val  = (64'(rdata) >> (8 * lane)) & mask;
      if (!uns && val[8 * bytes - 1]) val = val | ~mask;
      e_rw = 1'b1; e_id = id; e_data = val[31:0];
    end

    @(negedge clock);
    check_bubble();
    check_val("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pc = pc; in_alu_result = alu; in_store_data = sdata;
    in_mem_read = rd; in_mem_write = wr; in_size = size; in_unsigned = uns;
    in_reg_write = rw; in_reg_id = id; in_data_ready = dr;
    @(negedge clock);
    in_valid = 1'b0;
    in_reg_id = 5'($urandom); in_alu_result = $urandom;

    if (rd || wr) begin
      if (!ok) begin
        check_val("mis_err", 64'(err_misaligned), 64'd1);
        check_val("mis_out_valid", 64'(out_valid), 64'd0);
        check_val("mis_dm_req", 64'(dm_bus.req), 64'd0);
        check_val("mis_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        check_val("mis_err_pulse", 64'(err_misaligned), 64'd0);
        return;
      end
      for (int c = 1; c <= MW; c++) begin
        check_val("wait_dm_req", 64'(dm_bus.req), 64'd1);
        check_val("wait_in_ready", 64'(in_ready), 64'd0);
        check_val("wait_out_valid", 64'(out_valid), 64'd0);
        check_val("wait_dm_we", 64'(dm_bus.we), 64'(wr));
        check_val("wait_dm_addr", 64'(dm_bus.addr), 64'(alu & 32'hFFFF_FFFC));
        check_val("wait_dm_be", 64'(dm_bus.be), 64'(e_be));
        if (wr) check_val("wait_dm_wdata", 64'(dm_bus.wdata), 64'(e_wdata));
        dm_bus.ack   = (c == k);
        dm_bus.rdata = (c == k) ? rdata : $urandom;
        @(negedge clock);
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = $urandom;
        if (c == k) break;
      end
      check_val("post_dm_req", 64'(dm_bus.req), 64'd0);
      check_val("post_in_ready", 64'(in_ready), 64'd1);
      if (k > MW) begin
        check_val("to_err", 64'(err_timeout), 64'd1);
        check_val("to_out_valid", 64'(out_valid), 64'd0);
        // A late ack while idle must be ignored.
        dm_bus.ack = 1'b1;
        @(negedge clock);
        dm_bus.ack = 1'b0;
        check_val("to_err_pulse", 64'(err_timeout), 64'd0);
        check_val("late_ack_out_valid", 64'(out_valid), 64'd0);
        check_val("late_ack_dm_req", 64'(dm_bus.req), 64'd0);
        return;
      end
    end else begin
      check_val("alu_dm_req", 64'(dm_bus.req), 64'd0);
    end
    check_val("res_out_valid", 64'(out_valid), 64'd1);
    check_val("res_out_pc", 64'(out_pc), 64'(pc));
    check_val("res_out_reg_write", 64'(out_reg_write), 64'(e_rw));
    check_val("res_out_reg_id", 64'(out_reg_id), 64'(e_id));
    check_val("res_fwd_id", 64'(fwd_reg_id), 64'(e_id));
    check_val("res_fwd_ready", 64'(fwd_data_ready), 64'(e_ready));
    if (e_ready) begin
      check_val("res_out_data", 64'(out_data), 64'(e_data));
      check_val("res_fwd_data", 64'(fwd_data), 64'(e_data));
    end
    check_val("res_err_mis", 64'(err_misaligned), 64'd0);
    check_val("res_err_to", 64'(err_timeout), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rd, wr;
    bit [1:0]    sz;
    bit [31:0]   a;
    int unsigned r;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_alu_result = '0; in_store_data = '0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_reg_write = 1'b0; in_reg_id = '0; in_data_ready = 1'b0;
    dm_bus.ack = 1'b0; dm_bus.rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_dm_req", 64'(dm_bus.req), 64'd0);
    check_val("rst_dm_we", 64'(dm_bus.we), 64'd0);
    check_val("rst_err_mis", 64'(err_misaligned), 64'd0);
    check_val("rst_err_to", 64'(err_timeout), 64'd0);
    check_val("rst_out_reg_id", 64'(out_reg_id), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    // Ack while idle is ignored.
    dm_bus.ack = 1'b1; dm_bus.rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    dm_bus.ack = 1'b0;
    check_val("idle_ack_out_valid", 64'(out_valid), 64'd0);
    check_val("idle_ack_dm_req", 64'(dm_bus.req), 64'd0);

    // ALU op r5 = 0x1234, ready.
    do_op(0, 0, 2'd2, 0, 1, 5'd5, 1, 32'h1234, 32'h0, 32'h100, 0, 32'h0);
    // ALU op whose value is not yet final, and one that writes no register.
    do_op(0, 0, 2'd2, 0, 1, 5'd7, 0, 32'h5555, 32'h0, 32'h104, 0, 32'h0);
    do_op(0, 0, 2'd2, 0, 0, 5'd9, 1, 32'h7777, 32'h0, 32'h108, 0, 32'h0);
    // lb / lbu r3 @0x1003, ack in the 3rd WAIT cycle.
    do_op(1, 0, 2'd0, 0, 1, 5'd3, 0, 32'h1003, 32'h0, 32'h10C, 3, 32'h80FF_FFFF);
    do_op(1, 0, 2'd0, 1, 1, 5'd3, 0, 32'h1003, 32'h0, 32'h110, 3, 32'h80FF_FFFF);
    // lh signed from the upper half, lw aligned.
    do_op(1, 0, 2'd1, 0, 1, 5'd4, 0, 32'h4002, 32'h0, 32'h114, 1, 32'h9ABC_1234);
    do_op(1, 0, 2'd2, 0, 1, 5'd6, 0, 32'h4000, 32'h0, 32'h118, 2, 32'h8765_4321);
    // sh 0xBEEF @0x2002.
    do_op(0, 1, 2'd1, 0, 1, 5'd8, 0, 32'h2002, 32'h0000_BEEF, 32'h11C, 2, 32'h0);
    // lw @0x2001 misaligned; dword on a 32-bit path is illegal.
    do_op(1, 0, 2'd2, 0, 1, 5'd1, 0, 32'h2001, 32'h0, 32'h120, 1, 32'h0);
    do_op(1, 0, 2'd3, 0, 1, 5'd1, 0, 32'h2000, 32'h0, 32'h124, 1, 32'h0);
    // Never acked: times out after MAX_WAIT cycles.
    do_op(1, 0, 2'd2, 0, 1, 5'd2, 0, 32'h3000, 32'h0, 32'h128, MW + 1, 32'h0);

    // Reset asserted in the 2nd WAIT cycle drops the access.
    @(negedge clock);
    in_valid = 1'b1; in_pc = 32'h200; in_alu_result = 32'h5000; in_mem_read = 1'b1;
    in_mem_write = 1'b0; in_size = 2'd2; in_reg_write = 1'b1; in_reg_id = 5'd10;
    @(negedge clock);
    in_valid = 1'b0;
    check_val("rw_dm_req_1", 64'(dm_bus.req), 64'd1);
    @(negedge clock);
    check_val("rw_dm_req_2", 64'(dm_bus.req), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("rw_dm_req_after", 64'(dm_bus.req), 64'd0);
    check_val("rw_out_valid", 64'(out_valid), 64'd0);
    check_val("rw_in_ready", 64'(in_ready), 64'd1);
    do_op(1, 0, 2'd2, 1, 1, 5'd11, 0, 32'h5004, 32'h0, 32'h204, 1, 32'hCAFE_F00D);

    // Randomized instruction mix.
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 2);
      rd = (r == 1);
      wr = (r == 2);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      do_op(rd, wr, sz, 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), a,
            $urandom, $urandom, int'($urandom_range(1, MW + 1)), $urandom);
    end

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
